id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 155 +++++++++++++++
 tb/tb_id_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction decode stage: control decode, 32x32 register file with write-through
// bypass, load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_ID_Inst,
  input  logic [31:0] IF_ID_NewPC,
  input  logic        EX_MEM_Seletor,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteReg,
  input  logic [31:0] WB_WriteData,
  output logic        hazard,
  output logic        ID_EX_RegWrite,
  output logic        ID_EX_MemtoReg,
  output logic        ID_EX_MemRead,
  output logic        ID_EX_MemWrite,
  output logic        ID_EX_Branch,
  output logic        ID_EX_ALUSrc,
  output logic        ID_EX_RegDst,
  output logic [1:0]  ID_EX_ALUOp,
  output logic [31:0] ID_EX_NewPC,
  output logic [31:0] ID_EX_ReadData1,
  output logic [31:0] ID_EX_ReadData2,
  output logic [31:0] ID_EX_SignExt,
  output logic [4:0]  ID_EX_Rs,
  output logic [4:0]  ID_EX_Rt,
  output logic [4:0]  ID_EX_Rd
);

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_sext;

  assign w_op   = IF_ID_Inst[31:26];
  assign w_rs   = IF_ID_Inst[25:21];
  assign w_rt   = IF_ID_Inst[20:16];
  assign w_rd   = IF_ID_Inst[15:11];
  assign w_sext = {{16{IF_ID_Inst[15]}}, IF_ID_Inst[15:0]};

  logic       w_reg_write;
  logic       w_memto_reg;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_branch;
  logic       w_alu_src;
  logic       w_reg_dst;
  logic [1:0] w_alu_op;

  always_comb begin
    w_reg_write = 1'b0;
    w_memto_reg = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_alu_src   = 1'b0;
    w_reg_dst   = 1'b0;
    w_alu_op    = 2'b00;
    // The bubble word takes precedence even though it may alias a valid R-type.
    if (IF_ID_Inst != NOP_INST) begin
      case (w_op)
        6'h00: begin
          w_reg_write = 1'b1;
          w_reg_dst   = 1'b1;
          w_alu_op    = 2'b10;
        end
        6'h23: begin
          w_reg_write = 1'b1;
          w_memto_reg = 1'b1;
          w_mem_read  = 1'b1;
          w_alu_src   = 1'b1;
        end
        6'h2B: begin
          w_mem_write = 1'b1;
          w_alu_src   = 1'b1;
        end
        6'h04: begin
          w_branch = 1'b1;
          w_alu_op = 2'b01;
        end
        default: ;
      endcase
    end
  end

  logic [31:0] r_regs [32];
  logic        w_wb_en;

  assign w_wb_en = WB_RegWrite && (WB_WriteReg != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
    end else if (w_wb_en) begin
      r_regs[WB_WriteReg] <= WB_WriteData;
    end
  end

  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  // Writeback in the same cycle is forwarded so decode never sees a stale value.
  assign w_rd1 = (w_rs == 5'd0) ? 32'h0 :
                 (w_wb_en && WB_WriteReg == w_rs) ? WB_WriteData : r_regs[w_rs];
  assign w_rd2 = (w_rt == 5'd0) ? 32'h0 :
                 (w_wb_en && WB_WriteReg == w_rt) ? WB_WriteData : r_regs[w_rt];

  logic w_load_use;
  logic w_bubble;

  assign w_load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == w_rs) || (ID_EX_Rt == w_rt));
  assign hazard     = w_load_use && !EX_MEM_Seletor;
  assign w_bubble   = hazard || EX_MEM_Seletor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ID_EX_RegWrite  <= 1'b0;
      ID_EX_MemtoReg  <= 1'b0;
      ID_EX_MemRead   <= 1'b0;
      ID_EX_MemWrite  <= 1'b0;
      ID_EX_Branch    <= 1'b0;
      ID_EX_ALUSrc    <= 1'b0;
      ID_EX_RegDst    <= 1'b0;
      ID_EX_ALUOp     <= 2'b00;
      ID_EX_NewPC     <= 32'h0;
      ID_EX_ReadData1 <= 32'h0;
      ID_EX_ReadData2 <= 32'h0;
      ID_EX_SignExt   <= 32'h0;
      ID_EX_Rs        <= 5'd0;
      ID_EX_Rt        <= 5'd0;
      ID_EX_Rd        <= 5'd0;
    end else begin
      ID_EX_RegWrite  <= w_bubble ? 1'b0  : w_reg_write;
      ID_EX_MemtoReg  <= w_bubble ? 1'b0  : w_memto_reg;
      ID_EX_MemRead   <= w_bubble ? 1'b0  : w_mem_read;
      ID_EX_MemWrite  <= w_bubble ? 1'b0  : w_mem_write;
      ID_EX_Branch    <= w_bubble ? 1'b0  : w_branch;
      ID_EX_ALUSrc    <= w_bubble ? 1'b0  : w_alu_src;
      ID_EX_RegDst    <= w_bubble ? 1'b0  : w_reg_dst;
      ID_EX_ALUOp     <= w_bubble ? 2'b00 : w_alu_op;
      ID_EX_NewPC     <= IF_ID_NewPC;
      ID_EX_ReadData1 <= w_rd1;
      ID_EX_ReadData2 <= w_rd2;
      ID_EX_SignExt   <= w_sext;
      ID_EX_Rs        <= w_rs;
      ID_EX_Rt        <= w_rt;
      ID_EX_Rd        <= w_rd;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a behavioural model checked every negedge, plus
// hand-computed literal expectations along a directed instruction sequence.
module tb_id_stage;

  logic        clk;
  logic        reset;
  logic [31:0] IF_ID_Inst;
  logic [31:0] IF_ID_NewPC;
  logic        EX_MEM_Seletor;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic        hazard;
  logic        ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite;
  logic        ID_EX_Branch, ID_EX_ALUSrc, ID_EX_RegDst;
  logic [1:0]  ID_EX_ALUOp;
  logic [31:0] ID_EX_NewPC, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExt;
  logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;

  id_stage #(.NOP_INST(32'h00000000)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_Inst(IF_ID_Inst), .IF_ID_NewPC(IF_ID_NewPC),
    .EX_MEM_Seletor(EX_MEM_Seletor),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .hazard(hazard),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_Branch(ID_EX_Branch), .ID_EX_ALUSrc(ID_EX_ALUSrc),
    .ID_EX_RegDst(ID_EX_RegDst), .ID_EX_ALUOp(ID_EX_ALUOp),
    .ID_EX_NewPC(ID_EX_NewPC), .ID_EX_ReadData1(ID_EX_ReadData1),
    .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_SignExt(ID_EX_SignExt),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: control word {rw,mtr,mr,mw,br,as,rd,aluop[1:0]}
  logic [8:0]  m_ctrl;
  logic [31:0] m_npc, m_rd1, m_rd2, m_sext;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_regs [32];

  function automatic logic [8:0] model_decode(input logic [31:0] inst);
    if (inst == 32'h0) return 9'b0;
    case (inst[31:26])
      6'h00:   return 9'b1000001_10;
      6'h23:   return 9'b1110010_00;
      6'h2B:   return 9'b0001010_00;
      6'h04:   return 9'b0000100_01;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic model_hazard();
    logic [4:0] rs, rt;
    rs = IF_ID_Inst[25:21];
    rt = IF_ID_Inst[20:16];
    return m_ctrl[6] && m_rt != 0 && (m_rt == rs || m_rt == rt) && !EX_MEM_Seletor;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (WB_RegWrite && WB_WriteReg == a) return WB_WriteData;
    return m_regs[a];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ctrl = 0; m_npc = 0; m_rd1 = 0; m_rd2 = 0; m_sext = 0;
      m_rs = 0; m_rt = 0; m_rd = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
    end else begin
      logic kill;
      kill   = model_hazard() || EX_MEM_Seletor;
      m_ctrl = kill ? 9'b0 : model_decode(IF_ID_Inst);
      m_npc  = IF_ID_NewPC;
      m_rd1  = model_read(IF_ID_Inst[25:21]);
      m_rd2  = model_read(IF_ID_Inst[20:16]);
      m_sext = 32'($signed(IF_ID_Inst[15:0]));
      m_rs   = IF_ID_Inst[25:21];
      m_rt   = IF_ID_Inst[20:16];
      m_rd   = IF_ID_Inst[15:11];
      if (WB_RegWrite && WB_WriteReg != 0) m_regs[WB_WriteReg] = WB_WriteData;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("hazard",   32'(hazard),         32'(model_hazard()));
      check("RegWrite", 32'(ID_EX_RegWrite), 32'(m_ctrl[8]));
      check("MemtoReg", 32'(ID_EX_MemtoReg), 32'(m_ctrl[7]));
      check("MemRead",  32'(ID_EX_MemRead),  32'(m_ctrl[6]));
      check("MemWrite", 32'(ID_EX_MemWrite), 32'(m_ctrl[5]));
      check("Branch",   32'(ID_EX_Branch),   32'(m_ctrl[4]));
      check("ALUSrc",   32'(ID_EX_ALUSrc),   32'(m_ctrl[3]));
      check("RegDst",   32'(ID_EX_RegDst),   32'(m_ctrl[2]));
      check("ALUOp",    32'(ID_EX_ALUOp),    32'(m_ctrl[1:0]));
      check("NewPC",    ID_EX_NewPC,     m_npc);
      check("RD1",      ID_EX_ReadData1, m_rd1);
      check("RD2",      ID_EX_ReadData2, m_rd2);
      check("SignExt",  ID_EX_SignExt,   m_sext);
      check("Rs",       32'(ID_EX_Rs),   32'(m_rs));
      check("Rt",       32'(ID_EX_Rt),   32'(m_rt));
      check("Rd",       32'(ID_EX_Rd),   32'(m_rd));
    end
  end

  // driver tasks
  logic [31:0] pc = 32'h0000_1000;

  task automatic drive(input logic [31:0] inst);
    IF_ID_Inst  = inst;
    pc          = pc + 4;
    IF_ID_NewPC = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    WB_RegWrite  = en;
    WB_WriteReg  = r;
    WB_WriteData = d;
  endtask

  logic [31:0] vec [6];

  initial begin
    reset = 1'b0;
    IF_ID_Inst = 0; IF_ID_NewPC = 0; EX_MEM_Seletor = 0;
    wb(0, 0, 0);
    tick(); tick();
    chk_en = 1'b1;
    check("reset_memread", 32'(ID_EX_MemRead), 32'h0);
    check("reset_hazard",  32'(hazard),        32'h0);
    reset = 1'b1;

    // preload $1 = 100, $3 = 7
    drive(32'h0); wb(1, 5'd1, 32'd100); tick();
    wb(1, 5'd3, 32'd7); tick();
    wb(0, 0, 0);

    // lw $2,4($1)
    drive(32'h8C220004); tick();
    check("lw_memread",  32'(ID_EX_MemRead),  32'h1);
    check("lw_memtoreg", 32'(ID_EX_MemtoReg), 32'h1);
    check("lw_alusrc",   32'(ID_EX_ALUSrc),   32'h1);
    check("lw_rt",       32'(ID_EX_Rt),       32'h2);
    check("lw_sext",     ID_EX_SignExt,       32'h4);
    check("lw_rd1",      ID_EX_ReadData1,     32'd100);

    // add $2,$2,$3 -> one-cycle stall
    drive(32'h00431020); #1;
    check("lu_hazard", 32'(hazard), 32'h1);
    tick();
    check("lu_bubble_rw",  32'(ID_EX_RegWrite), 32'h0);
    check("lu_bubble_op",  32'(ID_EX_ALUOp),    32'h0);
    check("lu_bubble_rd2", ID_EX_ReadData2,     32'd7);
    check("lu_hazard_off", 32'(hazard),         32'h0);
    tick();
    check("add_regdst", 32'(ID_EX_RegDst), 32'h1);
    check("add_aluop",  32'(ID_EX_ALUOp),  32'h2);

    // load-use masked by taken branch
    drive(32'h8C220004); tick();
    drive(32'h00431020); EX_MEM_Seletor = 1; #1;
    check("sel_hazard", 32'(hazard), 32'h0);
    tick();
    check("sel_rw", 32'(ID_EX_RegWrite), 32'h0);
    check("sel_mr", 32'(ID_EX_MemRead),  32'h0);
    EX_MEM_Seletor = 0;

    // bypass and $0
    wb(1, 5'd5, 32'hDEADBEEF); drive(32'h00A03020); tick();
    check("bypass_rd1", ID_EX_ReadData1, 32'hDEADBEEF);
    wb(1, 5'd0, 32'h12345678); drive(32'h00001020); tick();
    check("zero_rd1", ID_EX_ReadData1, 32'h0);
    wb(0, 0, 0); drive(32'h00A03020); tick();
    check("stored_rd1", ID_EX_ReadData1, 32'hDEADBEEF);

    // beq, illegal opcode, sw
    drive(32'h1085FFFE); tick();
    check("beq_branch", 32'(ID_EX_Branch), 32'h1);
    check("beq_aluop",  32'(ID_EX_ALUOp),  32'h1);
    check("beq_sext",   ID_EX_SignExt,     32'hFFFFFFFE);
    drive(32'hFC000000); tick();
    check("op3f_rw", 32'(ID_EX_RegWrite), 32'h0);
    check("op3f_br", 32'(ID_EX_Branch),   32'h0);
    drive(32'hAC450008); tick();
    check("sw_memwrite", 32'(ID_EX_MemWrite), 32'h1);
    check("sw_rd2",      ID_EX_ReadData2,     32'hDEADBEEF);

    // mixed table, model checks each cycle
    vec[0] = 32'h8C660010; vec[1] = 32'h00C73820; vec[2] = 32'h00000000;
    vec[3] = 32'h1000FFFF; vec[4] = 32'h8CE8FFF0; vec[5] = 32'hAD070004;
    wb(1, 5'd6, 32'h0000_0055);
    for (int i = 0; i < 6; i++) begin
      drive(vec[i]);
      tick();
      if (hazard) tick();
    end
    wb(0, 0, 0);

    // async reset mid-cycle with nonzero outputs
    drive(32'h8C220004); tick();
    #2 reset = 1'b0; #1;
    check("arst_memread", 32'(ID_EX_MemRead), 32'h0);
    check("arst_sext",    ID_EX_SignExt,      32'h0);
    check("arst_npc",     ID_EX_NewPC,        32'h0);
    check("arst_hazard",  32'(hazard),        32'h0);
    wb(1, 5'd7, 32'hCAFEF00D); tick();
    wb(0, 0, 0);
    reset = 1'b1;
    drive(32'h00A73020); tick();
    check("post_rst_rw",  32'(ID_EX_RegWrite), 32'h1);
    check("post_rst_rd1", ID_EX_ReadData1,     32'h0);
    check("post_rst_rd2", ID_EX_ReadData2,     32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
